// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//
// Final pipeline stage. Accepts one execute result at a time over a
// valid/ready handshake and commits it either to the register-file write
// port (single-cycle pulse) or to data memory over a req/ack write port.
// It also counts retired instructions and keeps two sticky error flags.
//
// Optional feature macro: WB_FWD_EN
//   defined   -> o_fwd_* mirror the register-file write in the WR_REG cycle
//   undefined -> o_fwd_* are tied to zero
//
// Ports
//   clk, reset                  clock (posedge) / synchronous active-high reset
//   i_res_valid, i_opcode,
//   i_res, i_dest_reg,
//   i_dest_addr                 execute-stage result stream
//   o_ready                     stage can accept (drives execute i_next_ready)
//   o_rf_we/o_rf_waddr/
//   o_rf_wdata                  register-file write port
//   o_mem_req/o_mem_addr/
//   o_mem_wdata, i_mem_ack      memory write port (req held until ack/timeout)
//   o_retired                   retired-instruction count (wraps)
//   o_bad_opc, o_mem_err        sticky flags: unknown opcode / memory timeout
//   o_fwd_valid/o_fwd_reg/
//   o_fwd_data                  forwarding port
// -----------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef OPC_XOR
`define OPC_XOR   8'h10
`endif
`ifndef OPC_ADD
`define OPC_ADD   8'h11
`endif
`ifndef OPC_SUB
`define OPC_SUB   8'h12
`endif
`ifndef OPC_STORE
`define OPC_STORE 8'h20
`endif

module writeback_stage #(
  parameter int DATA_WIDTH    = `DATA_WIDTH,
  parameter int ADDRESS_WIDTH = `ADDRESS_WIDTH,
  parameter int CNT_WIDTH     = 32,
  parameter int MEM_TIMEOUT   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_res_valid,
  input  logic [7:0]               i_opcode,
  input  logic [DATA_WIDTH-1:0]    i_res,
  input  logic [3:0]               i_dest_reg,
  input  logic [ADDRESS_WIDTH-1:0] i_dest_addr,
  output logic                     o_ready,
  output logic                     o_rf_we,
  output logic [3:0]               o_rf_waddr,
  output logic [DATA_WIDTH-1:0]    o_rf_wdata,
  output logic                     o_mem_req,
  output logic [ADDRESS_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0]    o_mem_wdata,
  input  logic                     i_mem_ack,
  output logic [CNT_WIDTH-1:0]     o_retired,
  output logic                     o_bad_opc,
  output logic                     o_mem_err,
  output logic                     o_fwd_valid,
  output logic [3:0]               o_fwd_reg,
  output logic [DATA_WIDTH-1:0]    o_fwd_data
);

  // Wide enough to hold MEM_TIMEOUT-1; a 1-bit counter suffices for 0/1.
  localparam int TMO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_REG = 2'd1,
    WR_MEM = 2'd2,
    DROP   = 2'd3
  } state_t;

  state_t                     state_reg,   state_next;
  logic [DATA_WIDTH-1:0]      res_reg,     res_next;
  logic [3:0]                 dest_reg_reg, dest_reg_next;
  logic [ADDRESS_WIDTH-1:0]   addr_reg,    addr_next;
  logic [TMO_W-1:0]           tmo_cnt_reg, tmo_cnt_next;
  logic [CNT_WIDTH-1:0]       retired_reg, retired_next;
  logic                       bad_opc_reg, bad_opc_next;
  logic                       mem_err_reg, mem_err_next;
  logic                       tmo_hit;

  // Last waiting cycle before giving up; never fires when MEM_TIMEOUT is 0.
  assign tmo_hit = (MEM_TIMEOUT != 0) && (32'(tmo_cnt_reg) == MEM_TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      res_reg      <= '0;
      dest_reg_reg <= '0;
      addr_reg     <= '0;
      tmo_cnt_reg  <= '0;
      retired_reg  <= '0;
      bad_opc_reg  <= 1'b0;
      mem_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      res_reg      <= res_next;
      dest_reg_reg <= dest_reg_next;
      addr_reg     <= addr_next;
      tmo_cnt_reg  <= tmo_cnt_next;
      retired_reg  <= retired_next;
      bad_opc_reg  <= bad_opc_next;
      mem_err_reg  <= mem_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    res_next      = res_reg;
    dest_reg_next = dest_reg_reg;
    addr_next     = addr_reg;
    tmo_cnt_next  = tmo_cnt_reg;
    retired_next  = retired_reg;
    bad_opc_next  = bad_opc_reg;
    mem_err_next  = mem_err_reg;

    case (state_reg)
      IDLE: begin
        // o_ready is high exactly in IDLE, so valid alone means a transfer.
        if (i_res_valid) begin
          res_next      = i_res;
          dest_reg_next = i_dest_reg;
          addr_next     = i_dest_addr;
          tmo_cnt_next  = '0;
          case (i_opcode)
            `OPC_XOR, `OPC_ADD, `OPC_SUB: state_next = WR_REG;
            `OPC_STORE:                   state_next = WR_MEM;
            default:                      state_next = DROP;
          endcase
        end
      end
      WR_REG: begin
        retired_next = retired_reg + CNT_WIDTH'(1);
        state_next   = IDLE;
      end
      WR_MEM: begin
        if (i_mem_ack) begin
          retired_next = retired_reg + CNT_WIDTH'(1);
          tmo_cnt_next = '0;
          state_next   = IDLE;
        end else if (tmo_hit) begin
          // Abandon the store: flag it, but it does not count as retired.
          mem_err_next = 1'b1;
          tmo_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
        end
      end
      DROP: begin
        bad_opc_next = 1'b1;
        retired_next = retired_reg + CNT_WIDTH'(1);
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Write ports show data only while their strobe is active, so they read
  // zero at reset and between transactions.
  assign o_ready     = (state_reg == IDLE);
  assign o_rf_we     = (state_reg == WR_REG);
  assign o_rf_waddr  = o_rf_we ? dest_reg_reg : '0;
  assign o_rf_wdata  = o_rf_we ? res_reg : '0;
  assign o_mem_req   = (state_reg == WR_MEM);
  assign o_mem_addr  = o_mem_req ? addr_reg : '0;
  assign o_mem_wdata = o_mem_req ? res_reg : '0;
  assign o_retired   = retired_reg;
  assign o_bad_opc   = bad_opc_reg;
  assign o_mem_err   = mem_err_reg;

`ifdef WB_FWD_EN
  assign o_fwd_valid = o_rf_we;
  assign o_fwd_reg   = o_rf_waddr;
  assign o_fwd_data  = o_rf_wdata;
`else
  assign o_fwd_valid = 1'b0;
  assign o_fwd_reg   = '0;
  assign o_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_writeback_stage
//
// Directed bench for writeback_stage. Expected register/memory commits are
// pushed to a queue as each instruction is issued and popped by a monitor
// when the DUT performs the write; other expectations are constants checked
// at fixed points of the sequence.
// -----------------------------------------------------------------------------
`ifndef OPC_XOR
`define OPC_XOR   8'h10
`endif
`ifndef OPC_ADD
`define OPC_ADD   8'h11
`endif
`ifndef OPC_SUB
`define OPC_SUB   8'h12
`endif
`ifndef OPC_STORE
`define OPC_STORE 8'h20
`endif

module tb_writeback_stage;

`ifdef WB_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        i_res_valid;
  logic [7:0]  i_opcode;
  logic [31:0] i_res;
  logic [3:0]  i_dest_reg;
  logic [31:0] i_dest_addr;
  logic        o_ready;
  logic        o_rf_we;
  logic [3:0]  o_rf_waddr;
  logic [31:0] o_rf_wdata;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] o_retired;
  logic        o_bad_opc;
  logic        o_mem_err;
  logic        o_fwd_valid;
  logic [3:0]  o_fwd_reg;
  logic [31:0] o_fwd_data;

  writeback_stage #(
    .DATA_WIDTH    (32),
    .ADDRESS_WIDTH (32),
    .CNT_WIDTH     (32),
    .MEM_TIMEOUT   (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_res_valid (i_res_valid),
    .i_opcode    (i_opcode),
    .i_res       (i_res),
    .i_dest_reg  (i_dest_reg),
    .i_dest_addr (i_dest_addr),
    .o_ready     (o_ready),
    .o_rf_we     (o_rf_we),
    .o_rf_waddr  (o_rf_waddr),
    .o_rf_wdata  (o_rf_wdata),
    .o_mem_req   (o_mem_req),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ack   (i_mem_ack),
    .o_retired   (o_retired),
    .o_bad_opc   (o_bad_opc),
    .o_mem_err   (o_mem_err),
    .o_fwd_valid (o_fwd_valid),
    .o_fwd_reg   (o_fwd_reg),
    .o_fwd_data  (o_fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_mem;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   req_cycles = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input bit is_mem, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    e.is_mem = is_mem;
    e.addr   = addr;
    e.data   = data;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: sample mid-cycle, pop one expectation per commit.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && o_mem_req) req_cycles++;
    if (!reset && o_rf_we) begin
      if (exp_q.size() == 0 || exp_q[0].is_mem) begin
        chk("unexpected_rf_we", 32'(o_rf_waddr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("rf_waddr", 32'(o_rf_waddr), e.addr);
        chk("rf_wdata", o_rf_wdata, e.data);
        chk("fwd_valid", 32'(o_fwd_valid), 32'(FWD_ON));
        chk("fwd_reg", 32'(o_fwd_reg), FWD_ON ? e.addr : 32'h0);
        chk("fwd_data", o_fwd_data, FWD_ON ? e.data : 32'h0);
      end
      $display("rf  write reg=%0d data=%h", o_rf_waddr, o_rf_wdata);
    end
    if (!reset && o_mem_req && i_mem_ack) begin
      if (exp_q.size() == 0 || !exp_q[0].is_mem) begin
        chk("unexpected_mem_commit", o_mem_addr, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("mem_addr", o_mem_addr, e.addr);
        chk("mem_wdata", o_mem_wdata, e.data);
      end
      $display("mem write addr=%h data=%h", o_mem_addr, o_mem_wdata);
    end
  end

  // Offer one instruction and hold it until the stage takes it. Returns
  // 1 ns after the accepting edge.
  task automatic send(input logic [7:0] opc, input logic [31:0] res,
                      input logic [3:0] rd, input logic [31:0] addr);
    bit got = 1'b0;
    i_res_valid = 1'b1;
    i_opcode    = opc;
    i_res       = res;
    i_dest_reg  = rd;
    i_dest_addr = addr;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (o_ready === 1'b1) got = 1'b1;
    end
    chk("send_accepted", 32'(got), 32'h1);
    @(posedge clk);
    #1;
    $display("issue opc=%h res=%h rd=%0d addr=%h", opc, res, rd, addr);
    i_res_valid = 1'b0;
    i_opcode    = '0;
    i_res       = '0;
    i_dest_reg  = '0;
    i_dest_addr = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit dropped;
    reset       = 1'b1;
    i_res_valid = 1'b0;
    i_opcode    = '0;
    i_res       = '0;
    i_dest_reg  = '0;
    i_dest_addr = '0;
    i_mem_ack   = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state after 5 idle cycles.
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",     32'(o_ready),     32'h1);
    chk("rst_rf_we",     32'(o_rf_we),     32'h0);
    chk("rst_mem_req",   32'(o_mem_req),   32'h0);
    chk("rst_retired",   o_retired,        32'h0);
    chk("rst_bad_opc",   32'(o_bad_opc),   32'h0);
    chk("rst_mem_err",   32'(o_mem_err),   32'h0);
    chk("rst_fwd_valid", 32'(o_fwd_valid), 32'h0);
    $display("reset check done");
    @(posedge clk); #1;

    // XOR to r3: write one cycle after accept, ready back the cycle after.
    push_exp(1'b0, 32'd3, 32'hA5A5_0F0F);
    send(`OPC_XOR, 32'hA5A5_0F0F, 4'd3, 32'h0);
    @(negedge clk);
    chk("xor_we_n1",      32'(o_rf_we), 32'h1);
    chk("xor_ready_n1",   32'(o_ready), 32'h0);
    chk("xor_retired_n1", o_retired,    32'h0);
    @(negedge clk);
    chk("xor_we_n2",      32'(o_rf_we), 32'h0);
    chk("xor_ready_n2",   32'(o_ready), 32'h1);
    chk("xor_retired_n2", o_retired,    32'h1);
    @(posedge clk); #1;

    // STORE acked in its third request cycle.
    req_cycles = 0;
    push_exp(1'b1, 32'h40, 32'h1234);
    send(`OPC_STORE, 32'h1234, 4'd9, 32'h40);
    for (int c = 0; c < 3; c++) begin
      if (c == 2) i_mem_ack = 1'b1;
      @(negedge clk);
      chk("st_req",   32'(o_mem_req), 32'h1);
      chk("st_addr",  o_mem_addr,     32'h40);
      chk("st_wdata", o_mem_wdata,    32'h1234);
      chk("st_no_we", 32'(o_rf_we),   32'h0);
      @(posedge clk); #1;
    end
    i_mem_ack = 1'b0;
    @(negedge clk);
    chk("st_req_done", 32'(o_mem_req), 32'h0);
    chk("st_req_cyc",  32'(req_cycles), 32'd3);
    chk("st_retired",  o_retired,       32'h2);
    chk("st_ready",    32'(o_ready),    32'h1);
    @(posedge clk); #1;

    // STORE never acked: gives up after 16 request cycles, no retire.
    req_cycles = 0;
    dropped = 1'b0;
    send(`OPC_STORE, 32'hBEEF, 4'd0, 32'h80);
    for (int c = 0; c < 40 && !dropped; c++) begin
      @(negedge clk);
      if (o_mem_req !== 1'b1) dropped = 1'b1;
    end
    chk("tmo_req_dropped", 32'(dropped),    32'h1);
    chk("tmo_req_cyc",     32'(req_cycles), 32'd16);
    chk("tmo_mem_err",     32'(o_mem_err),  32'h1);
    chk("tmo_retired",     o_retired,       32'h2);
    // Ack while idle must be ignored.
    @(posedge clk); #1 i_mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1 i_mem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_retired", o_retired,       32'h2);
    chk("idle_ack_req",     32'(o_mem_req),  32'h0);
    chk("idle_ack_err",     32'(o_mem_err),  32'h1);
    @(posedge clk); #1;

    // Unknown opcode: dropped, counted, sticky flag.
    send(8'hEE, 32'hDEAD_BEEF, 4'd5, 32'h100);
    @(negedge clk);
    chk("bad_no_we",  32'(o_rf_we),   32'h0);
    chk("bad_no_req", 32'(o_mem_req), 32'h0);
    @(negedge clk);
    chk("bad_flag",    32'(o_bad_opc), 32'h1);
    chk("bad_retired", o_retired,      32'h3);
    @(posedge clk); #1;

    // Back-to-back SUB to r0 then ADD to r7; second waits for ready.
    push_exp(1'b0, 32'd0, 32'h0000_0055);
    send(`OPC_SUB, 32'h0000_0055, 4'd0, 32'h0);
    push_exp(1'b0, 32'd7, 32'h0000_0777);
    send(`OPC_ADD, 32'h0000_0777, 4'd7, 32'h0);
    @(negedge clk);
    chk("add_we",        32'(o_rf_we),     32'h1);
    chk("add_fwd_valid", 32'(o_fwd_valid), 32'(FWD_ON));
    @(negedge clk);
    chk("add_retired",     o_retired,       32'h5);
    chk("add_fwd_off",     32'(o_fwd_valid), 32'h0);
    chk("bad_flag_sticky", 32'(o_bad_opc),  32'h1);
    @(posedge clk); #1;

    // Reset while a store is pending.
    send(`OPC_STORE, 32'h5555, 4'd1, 32'hC0);
    @(negedge clk);
    chk("rstmem_req_before", 32'(o_mem_req), 32'h1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rstmem_req",     32'(o_mem_req), 32'h0);
    chk("rstmem_we",      32'(o_rf_we),   32'h0);
    chk("rstmem_retired", o_retired,      32'h0);
    chk("rstmem_bad",     32'(o_bad_opc), 32'h0);
    chk("rstmem_err",     32'(o_mem_err), 32'h0);
    chk("rstmem_ready",   32'(o_ready),   32'h1);
    $display("reset-in-store check done");

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
